// File: rtl/trireg_hold_bank_if.sv
// Purpose: bundles the per-channel mode/data/refresh inputs and held-value outputs of trireg_hold_bank.
// Latency: none; this is wiring only.
// Backpressure: none; there is no handshake, and every field is sampled or presented each cycle.
interface trireg_hold_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic [2*NCH-1:0]     ch_mode;
  logic [WIDTH*NCH-1:0] ch_din;
  logic                 refresh;
  logic [WIDTH*NCH-1:0] ch_dout;
  logic [NCH-1:0]       ch_charged;
  logic [NCH-1:0]       ch_decay_evt;
  logic                 any_charged;

  // Control side: drives modes, data and refresh, and observes the held values.
  modport master (
    output ch_mode, ch_din, refresh,
    input  ch_dout, ch_charged, ch_decay_evt, any_charged
  );

  // Hold bank side.
  modport slave (
    input  ch_mode, ch_din, refresh,
    output ch_dout, ch_charged, ch_decay_evt, any_charged
  );
endinterface

// File: rtl/trireg_hold_bank.sv
// Purpose: multi-channel charge-retaining hold register with timed decay to an uncharged value.
// Latency: 1 cycle from the mode/din sampled at an edge to every registered output after that edge.
// Backpressure: none; each channel accepts its mode on every edge.
module trireg_hold_bank #(
  parameter int WIDTH        = 8,
  parameter int NCH          = 4,
  parameter int DECAY_CYCLES = 16,
  parameter int CONST_VAL    = 255,
  parameter int DECAY_VALUE  = 0
) (
  input logic             clk,
  input logic             rst_n,
  trireg_hold_bank_if.slave bus
);

  // The timer holds 0..DECAY_CYCLES. It keeps one dummy bit when decay is disabled.
  localparam int TW = (DECAY_CYCLES == 0) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [TW-1:0]    TMR_LOAD = TW'(DECAY_CYCLES);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [WIDTH-1:0] CONST_W  = WIDTH'(CONST_VAL);
  localparam logic [WIDTH-1:0] DECAY_W  = WIDTH'(DECAY_VALUE);

  logic [WIDTH*NCH-1:0] dout_q, dout_d;
  logic [TW*NCH-1:0]    tmr_q, tmr_d;
  logic [NCH-1:0]       chg_q, chg_d;
  logic [NCH-1:0]       evt_q, evt_d;
  logic                 any_q;

  // Per-channel next state. A drive or a refresh takes priority over expiry on the same edge.
  always_comb begin
    dout_d = dout_q;
    tmr_d  = tmr_q;
    chg_d  = chg_q;
    evt_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      case (bus.ch_mode[2*i +: 2])
        2'd1: begin
          dout_d[WIDTH*i +: WIDTH] = bus.ch_din[WIDTH*i +: WIDTH];
          chg_d[i]                 = 1'b1;
          tmr_d[TW*i +: TW]        = TMR_LOAD;
        end
        2'd2: begin
          dout_d[WIDTH*i +: WIDTH] = CONST_W;
          chg_d[i]                 = 1'b1;
          tmr_d[TW*i +: TW]        = TMR_LOAD;
        end
        2'd3: begin
          // Explicit discharge is deliberately not reported as a decay event.
          dout_d[WIDTH*i +: WIDTH] = DECAY_W;
          chg_d[i]                 = 1'b0;
          tmr_d[TW*i +: TW]        = '0;
        end
        default: begin
          // Hold. An uncharged channel already presents DECAY_VALUE and ignores refresh.
          if (DECAY_CYCLES != 0 && chg_q[i]) begin
            if (bus.refresh) begin
              tmr_d[TW*i +: TW] = TMR_LOAD;
            end else if (tmr_q[TW*i +: TW] > TMR_ONE) begin
              tmr_d[TW*i +: TW] = tmr_q[TW*i +: TW] - TMR_ONE;
            end else if (tmr_q[TW*i +: TW] == TMR_ONE) begin
              tmr_d[TW*i +: TW]        = '0;
              chg_d[i]                 = 1'b0;
              dout_d[WIDTH*i +: WIDTH] = DECAY_W;
              evt_d[i]                 = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers. any_charged is taken from the next-state charged bits so it stays aligned with ch_charged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= {NCH{DECAY_W}};
      tmr_q  <= '0;
      chg_q  <= '0;
      evt_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tmr_q  <= tmr_d;
      chg_q  <= chg_d;
      evt_q  <= evt_d;
      any_q  <= |chg_d;
    end
  end

  assign bus.ch_dout      = dout_q;
  assign bus.ch_charged   = chg_q;
  assign bus.ch_decay_evt = evt_q;
  assign bus.any_charged  = any_q;

endmodule

// File: tb/tb_trireg_hold_bank.sv
// Purpose: directed self-checking bench for trireg_hold_bank with DECAY_CYCLES=4.
// Latency: outputs are checked 1 ns after the edge that sampled the inputs.
// Backpressure: none.
module tb_trireg_hold_bank;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  trireg_hold_bank_if #(.WIDTH(8), .NCH(4)) bus ();

  trireg_hold_bank #(
    .WIDTH(8), .NCH(4), .DECAY_CYCLES(4), .CONST_VAL(255), .DECAY_VALUE(0)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stimulus helpers.
  task automatic set_ch(input int ch, input logic [1:0] m, input logic [7:0] d);
    bus.ch_mode[2*ch +: 2] = m;
    bus.ch_din[8*ch +: 8]  = d;
  endtask

  task automatic hold_all();
    bus.ch_mode = '0;
    bus.refresh = 1'b0;
  endtask

  // Advance one active edge, then settle 1 ns so the registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ch_mode = '0;
    bus.ch_din  = '0;
    bus.refresh = 1'b0;
    #12;
    vectors++;
    if (bus.ch_dout !== 32'h0 || bus.ch_charged !== 4'h0 || bus.ch_decay_evt !== 4'h0 || bus.any_charged !== 1'b0) begin
      $display("FAIL reset_state: dout=%h chg=%b evt=%b any=%b, required 0/0000/0000/0",
               bus.ch_dout, bus.ch_charged, bus.ch_decay_evt, bus.any_charged);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (bus.ch_dout !== 32'h0 || bus.ch_charged !== 4'h0 || bus.ch_decay_evt !== 4'h0 || bus.any_charged !== 1'b0) begin
        $display("FAIL idle_after_reset cyc%0d: dout=%h chg=%b evt=%b any=%b, required all 0",
                 k, bus.ch_dout, bus.ch_charged, bus.ch_decay_evt, bus.any_charged);
        miscompares++;
      end
    end
  endtask

  task automatic test_drive_decay();
    set_ch(0, 2'd1, 8'd10);
    step();
    vectors++;
    if (bus.ch_dout[7:0] !== 8'd10 || bus.ch_charged[0] !== 1'b1 || bus.any_charged !== 1'b1) begin
      $display("FAIL drive_ch0: dout0=%0d chg0=%b any=%b, required 10/1/1",
               bus.ch_dout[7:0], bus.ch_charged[0], bus.any_charged);
      miscompares++;
    end
    hold_all();
    // Timer is loaded with 4, so the first three hold edges still show the value.
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if (bus.ch_dout[7:0] !== 8'd10 || bus.ch_charged[0] !== 1'b1 || bus.ch_decay_evt[0] !== 1'b0) begin
        $display("FAIL hold_ch0 edge%0d: dout0=%0d chg0=%b evt0=%b, required 10/1/0",
                 k, bus.ch_dout[7:0], bus.ch_charged[0], bus.ch_decay_evt[0]);
        miscompares++;
      end
    end
    step();
    vectors++;
    if (bus.ch_dout[7:0] !== 8'd0 || bus.ch_charged[0] !== 1'b0 || bus.ch_decay_evt !== 4'b0001 || bus.any_charged !== 1'b0) begin
      $display("FAIL decay_ch0: dout0=%0d chg0=%b evt=%b any=%b, required 0/0/0001/0",
               bus.ch_dout[7:0], bus.ch_charged[0], bus.ch_decay_evt, bus.any_charged);
      miscompares++;
    end
    step();
    vectors++;
    if (bus.ch_decay_evt !== 4'b0000 || bus.ch_charged[0] !== 1'b0) begin
      $display("FAIL decay_pulse_width: evt=%b chg0=%b, required 0000/0", bus.ch_decay_evt, bus.ch_charged[0]);
      miscompares++;
    end
  endtask

  task automatic test_const_then_data();
    set_ch(1, 2'd2, 8'd0);
    step();
    vectors++;
    if (bus.ch_dout[15:8] !== 8'd255 || bus.ch_charged[1] !== 1'b1) begin
      $display("FAIL const_ch1: dout1=%0d chg1=%b, required 255/1", bus.ch_dout[15:8], bus.ch_charged[1]);
      miscompares++;
    end
    hold_all();
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (bus.ch_dout[15:8] !== 8'd255 || bus.ch_charged[1] !== 1'b1 || bus.ch_decay_evt[1] !== 1'b0) begin
        $display("FAIL const_hold_ch1 edge%0d: dout1=%0d chg1=%b evt1=%b, required 255/1/0",
                 k, bus.ch_dout[15:8], bus.ch_charged[1], bus.ch_decay_evt[1]);
        miscompares++;
      end
    end
    set_ch(1, 2'd1, 8'd30);
    step();
    hold_all();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (bus.ch_dout[15:8] !== 8'd30 || bus.ch_charged[1] !== 1'b1 || bus.ch_decay_evt[1] !== 1'b0) begin
        $display("FAIL data_hold_ch1 step%0d: dout1=%0d chg1=%b evt1=%b, required 30/1/0",
                 k, bus.ch_dout[15:8], bus.ch_charged[1], bus.ch_decay_evt[1]);
        miscompares++;
      end
      if (k < 3) step();
    end
    set_ch(1, 2'd3, 8'd0);
    step();
    hold_all();
    vectors++;
    if (bus.ch_charged !== 4'b0000 || bus.ch_decay_evt !== 4'b0000) begin
      $display("FAIL discharge_ch1: chg=%b evt=%b, required 0000/0000", bus.ch_charged, bus.ch_decay_evt);
      miscompares++;
    end
  endtask

  task automatic test_refresh();
    set_ch(2, 2'd1, 8'd30);
    step();
    hold_all();
    for (int k = 0; k < 20; k++) begin
      bus.refresh = (k % 3 == 2);
      step();
      vectors++;
      if (bus.ch_dout[23:16] !== 8'd30 || bus.ch_charged[2] !== 1'b1 || bus.ch_decay_evt[2] !== 1'b0) begin
        $display("FAIL refresh_ch2 cyc%0d: dout2=%0d chg2=%b evt2=%b, required 30/1/0",
                 k, bus.ch_dout[23:16], bus.ch_charged[2], bus.ch_decay_evt[2]);
        miscompares++;
      end
      vectors++;
      if (bus.ch_dout[31:24] !== 8'd0 || bus.ch_charged[3] !== 1'b0) begin
        $display("FAIL refresh_uncharged_ch3 cyc%0d: dout3=%0d chg3=%b, required 0/0",
                 k, bus.ch_dout[31:24], bus.ch_charged[3]);
        miscompares++;
      end
    end
    set_ch(2, 2'd3, 8'd0);
    bus.refresh = 1'b0;
    step();
    hold_all();
  endtask

  task automatic test_discharge_and_collisions();
    set_ch(0, 2'd1, 8'd10);
    step();
    set_ch(0, 2'd3, 8'd0);
    step();
    hold_all();
    vectors++;
    if (bus.ch_dout[7:0] !== 8'd0 || bus.ch_charged[0] !== 1'b0 || bus.ch_decay_evt[0] !== 1'b0) begin
      $display("FAIL discharge_ch0: dout0=%0d chg0=%b evt0=%b, required 0/0/0",
               bus.ch_dout[7:0], bus.ch_charged[0], bus.ch_decay_evt[0]);
      miscompares++;
    end
    step();
    vectors++;
    if (bus.ch_decay_evt !== 4'b0000) begin
      $display("FAIL discharge_no_evt: evt=%b, required 0000", bus.ch_decay_evt);
      miscompares++;
    end
    // Drive on the would-be expiry edge: reload, no pulse.
    set_ch(0, 2'd1, 8'd10);
    step();
    hold_all();
    repeat (3) step();
    set_ch(0, 2'd1, 8'd77);
    step();
    hold_all();
    vectors++;
    if (bus.ch_dout[7:0] !== 8'd77 || bus.ch_charged[0] !== 1'b1 || bus.ch_decay_evt[0] !== 1'b0) begin
      $display("FAIL drive_at_expiry: dout0=%0d chg0=%b evt0=%b, required 77/1/0",
               bus.ch_dout[7:0], bus.ch_charged[0], bus.ch_decay_evt[0]);
      miscompares++;
    end
    repeat (3) step();
    vectors++;
    if (bus.ch_charged[0] !== 1'b1 || bus.ch_decay_evt[0] !== 1'b0) begin
      $display("FAIL reload_after_drive: chg0=%b evt0=%b, required 1/0", bus.ch_charged[0], bus.ch_decay_evt[0]);
      miscompares++;
    end
    // Refresh on the would-be expiry edge: no decay.
    bus.refresh = 1'b1;
    step();
    bus.refresh = 1'b0;
    vectors++;
    if (bus.ch_dout[7:0] !== 8'd77 || bus.ch_charged[0] !== 1'b1 || bus.ch_decay_evt[0] !== 1'b0) begin
      $display("FAIL refresh_at_expiry: dout0=%0d chg0=%b evt0=%b, required 77/1/0",
               bus.ch_dout[7:0], bus.ch_charged[0], bus.ch_decay_evt[0]);
      miscompares++;
    end
    repeat (3) step();
    vectors++;
    if (bus.ch_charged[0] !== 1'b1) begin
      $display("FAIL refresh_reload_len: chg0=%b, required 1", bus.ch_charged[0]);
      miscompares++;
    end
    step();
    vectors++;
    if (bus.ch_charged[0] !== 1'b0 || bus.ch_decay_evt !== 4'b0001 || bus.ch_dout[7:0] !== 8'd0) begin
      $display("FAIL decay_after_refresh: chg0=%b evt=%b dout0=%0d, required 0/0001/0",
               bus.ch_charged[0], bus.ch_decay_evt, bus.ch_dout[7:0]);
      miscompares++;
    end
    step();
  endtask

  task automatic test_reset_midcount();
    set_ch(0, 2'd1, 8'd11);
    set_ch(1, 2'd1, 8'd22);
    set_ch(2, 2'd1, 8'd33);
    set_ch(3, 2'd2, 8'd0);
    step();
    hold_all();
    vectors++;
    if (bus.ch_dout !== 32'hFF21160B || bus.ch_charged !== 4'b1111 || bus.any_charged !== 1'b1) begin
      $display("FAIL all_charged: dout=%h chg=%b any=%b, required ff21160b/1111/1",
               bus.ch_dout, bus.ch_charged, bus.any_charged);
      miscompares++;
    end
    repeat (2) step();
    // Timers now at 2; assert reset mid-cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.ch_dout !== 32'h0 || bus.ch_charged !== 4'h0 || bus.ch_decay_evt !== 4'h0 || bus.any_charged !== 1'b0) begin
      $display("FAIL async_reset: dout=%h chg=%b evt=%b any=%b, required 0/0000/0000/0",
               bus.ch_dout, bus.ch_charged, bus.ch_decay_evt, bus.any_charged);
      miscompares++;
    end
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (bus.ch_decay_evt !== 4'h0 || bus.ch_charged !== 4'h0 || bus.ch_dout !== 32'h0) begin
        $display("FAIL post_reset cyc%0d: evt=%b chg=%b dout=%h, required 0000/0000/0",
                 k, bus.ch_decay_evt, bus.ch_charged, bus.ch_dout);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_drive_decay();
    test_const_then_data();
    test_refresh();
    test_discharge_and_collisions();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
